// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit between the core MEM stage and a req/gnt/rvalid
// data-memory port. Stalls the core while an access is in flight and returns
// byte/half/word load data extended to 32 bits.
// Optional build macro MISALIGNED_SPLIT_EN: misaligned accesses are serviced
// (word-crossing ones as two beats) instead of raising fault_misalign.
module lsu_dmem #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault_misalign,
    output logic        fault_illegal,
    output logic        fault_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // Last counter value before a wait is declared a bus error.
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
    localparam bit          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fm_q, fm_d;
    logic        fi_q, fi_d;
    logic        fb_q, fb_d;

    logic        illegal_s, misal_s, split_s, timeout_s, busy_s;
    logic [7:0]  wide_strb_s;
    logic [31:0] word_addr_s, lane_wdata_s, ext_s, lo_s, hi_s;

    // Byte-enable pattern of an access of the given size at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store datum across lanes, then rotate so the low byte
    // sits on lane addr[1:0]; aligned accesses see plain replication and
    // word-crossing accesses get the right bytes on both beats.
    function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off);
        logic [31:0] rep;
        logic [5:0]  sh;
        case (size)
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        sh = {1'b0, off, 3'b000};
        return (rep << sh) | (rep >> (6'd32 - sh));
    endfunction

    // Shift the (possibly two-word) read data down to the accessed byte and extend.
    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [63:0] pair,
                                             input logic [1:0]  off);
        logic [31:0] w;
        w = 32'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign done           = (state_q == DONE);
    assign stall          = (load | store) & ~done;
    assign rdata          = rdata_q;
    assign fault_misalign = fm_q;
    assign fault_illegal  = fi_q;
    assign fault_bus      = fb_q;

    // Access classification and datapath helpers
    always_comb begin
        illegal_s = (load & store)
                  | (load  & ~(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                  | (store & ~(funct3 inside {3'b000, 3'b001, 3'b010}));
        misal_s   = ~SPLIT_EN & (((funct3[1:0] == 2'b01) & addr[0])
                               | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
        wide_strb_s  = {4'b0000, size_mask(f3_q[1:0])} << addr_q[1:0];
        split_s      = SPLIT_EN & (wide_strb_s[7:4] != 4'b0000);
        word_addr_s  = {addr_q[31:2], 2'b00};
        lane_wdata_s = lane_data(f3_q[1:0], wdata_q, addr_q[1:0]);
        lo_s         = (state_q == WAIT1) ? mem_rdata : rd1_q;
        hi_s         = (state_q == WAIT2) ? mem_rdata : 32'd0;
        ext_s        = load_ext(f3_q, {hi_s, lo_s}, addr_q[1:0]);
        busy_s       = (state_q inside {REQ1, WAIT1, REQ2, WAIT2});
        timeout_s    = TO_EN & (cnt_q == TO_LAST);
    end

    // Next-state logic: access acceptance, handshake sequencing, completion
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rd1_d   = rd1_q;
        rdata_d = rdata_q;
        fm_d    = 1'b0;
        fi_d    = 1'b0;
        fb_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load | store) begin
                    addr_d  = addr;
                    f3_d    = funct3;
                    wdata_d = wdata;
                    we_d    = store;
                    if (illegal_s) begin
                        state_d = DONE;
                        fi_d    = 1'b1;
                        rdata_d = 32'd0;
                    end else if (misal_s) begin
                        state_d = DONE;
                        fm_d    = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = REQ1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ1, REQ2: begin
                if (mem_gnt) begin
                    if (!we_q) begin
                        state_d = (state_q == REQ1) ? WAIT1 : WAIT2;
                    end else if ((state_q == REQ1) && split_s) begin
                        state_d = REQ2;
                    end else begin
                        state_d = DONE;
                        rdata_d = 32'd0;
                    end
                end else if (timeout_s) begin
                    state_d = DONE;
                    fb_d    = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT1, WAIT2: begin
                if (mem_rvalid) begin
                    rd1_d = mem_rdata;
                    if ((state_q == WAIT1) && split_s) begin
                        state_d = REQ2;
                    end else begin
                        state_d = DONE;
                        rdata_d = ext_s;
                    end
                end else if (timeout_s) begin
                    state_d = DONE;
                    fb_d    = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cnt_d = (busy_s && (state_d == state_q)) ? cnt_q + 32'd1 : 32'd0;
    end

    // Memory-side outputs decoded from the registered state and latched access
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'd0;
        case (state_q)
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = word_addr_s;
                mem_wstrb = we_q ? wide_strb_s[3:0] : 4'b0000;
                mem_wdata = we_q ? lane_wdata_s : 32'd0;
            end
            REQ2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = word_addr_s + 32'd4;
                mem_wstrb = we_q ? wide_strb_s[7:4] : 4'b0000;
                mem_wdata = we_q ? lane_wdata_s : 32'd0;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rd1_q   <= 32'd0;
            cnt_q   <= 32'd0;
            rdata_q <= 32'd0;
            fm_q    <= 1'b0;
            fi_q    <= 1'b0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rd1_q   <= rd1_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fm_q    <= fm_d;
            fi_q    <= fi_d;
            fb_q    <= fb_d;
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed, table-driven bench for lsu_dmem with a small req/gnt/rvalid
// memory responder; instantiated with TIMEOUT=8.
module tb_lsu_dmem;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done;
    logic [31:0] rdata;
    logic        fault_misalign, fault_illegal, fault_bus;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_dmem #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .fault_misalign(fault_misalign), .fault_illegal(fault_illegal),
        .fault_bus(fault_bus), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          gdly;
        logic [31:0] r1, r2;
        int          lat, beats;
        logic        chk_rd;
        logic [31:0] rd;
        logic        fm, fi, fb;
        logic [31:0] ma;
        logic [3:0]  ms;
        logic        chk_wd;
        logic [31:0] mw;
    } vec_t;

    int n_app = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_app++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, int gdly, logic [31:0] r1, logic [31:0] r2,
                                int lat, int beats, logic chk_rd, logic [31:0] rd,
                                logic fm, logic fi, logic fb, logic [31:0] ma,
                                logic [3:0] ms, logic chk_wd, logic [31:0] mw);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.gdly = gdly;
        v.r1 = r1; v.r2 = r2; v.lat = lat; v.beats = beats; v.chk_rd = chk_rd;
        v.rd = rd; v.fm = fm; v.fi = fi; v.fb = fb; v.ma = ma; v.ms = ms;
        v.chk_wd = chk_wd; v.mw = mw;
        return v;
    endfunction

    // Apply one access starting at a negedge with the DUT idle; act as memory.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, wcnt, beats;
        bit rvp, in_beat, stable, stall_ok;
        logic [31:0] rvd, ca, cd, a0, d0;
        logic [3:0]  cs, s0;
        logic        cw, w0;
        string p;
        p = $sformatf("v%0d", idx);
        load = v.ld; store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
        cyc = 0; wcnt = 0; beats = 0; rvp = 0; in_beat = 0; stable = 1; stall_ok = 1;
        rvd = 32'd0; ca = 32'd0; cd = 32'd0; cs = 4'd0; cw = 1'b0;
        a0 = 32'd0; d0 = 32'd0; s0 = 4'd0; w0 = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            #1;
            if (stall !== 1'b1) stall_ok = 0;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
            if (rvp) begin
                mem_rvalid = 1'b1; mem_rdata = rvd; rvp = 0;
            end
            if (mem_req === 1'b1) begin
                if (!in_beat) begin
                    in_beat = 1; beats++;
                    ca = mem_addr; cs = mem_wstrb; cd = mem_wdata; cw = mem_we;
                    if (beats == 1) begin a0 = ca; s0 = cs; d0 = cd; w0 = cw; end
                end else if (mem_addr !== ca || mem_wstrb !== cs || mem_wdata !== cd || mem_we !== cw) begin
                    stable = 0;
                end
                if (wcnt >= v.gdly) begin
                    mem_gnt = 1'b1; wcnt = 0; in_beat = 0;
                    if (mem_we !== 1'b1) begin
                        rvp = 1; rvd = (beats == 1) ? v.r1 : v.r2;
                    end
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        chk1({p, ".done"}, done, 1'b1);
        check({p, ".latency"}, 32'(cyc), 32'(v.lat));
        chk1({p, ".stall_busy"}, stall_ok, 1'b1);
        chk1({p, ".stall_at_done"}, stall, 1'b0);
        if (v.chk_rd) check({p, ".rdata"}, rdata, v.rd);
        chk1({p, ".fault_misalign"}, fault_misalign, v.fm);
        chk1({p, ".fault_illegal"}, fault_illegal, v.fi);
        chk1({p, ".fault_bus"}, fault_bus, v.fb);
        check({p, ".beats"}, 32'(beats), 32'(v.beats));
        chk1({p, ".mem_stable"}, stable, 1'b1);
        if (v.beats > 0) begin
            check({p, ".mem_addr"}, a0, v.ma);
            check({p, ".mem_wstrb"}, {28'd0, s0}, {28'd0, v.ms});
            chk1({p, ".mem_we"}, w0, v.st);
            if (v.chk_wd) check({p, ".mem_wdata"}, d0, v.mw);
        end
        load = 1'b0; store = 1'b0;
        @(negedge clk); #1;
        chk1({p, ".done_pulse"}, done, 1'b0);
        if (v.chk_rd) check({p, ".rdata_hold"}, rdata, v.rd);
        chk1({p, ".idle_req"}, mem_req, 1'b0);
        @(negedge clk);
    endtask

    vec_t tbl[16];

    initial begin
        bit saw_done;
        rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        @(negedge clk); @(negedge clk); #1;
        chk1("rst.done", done, 1'b0);
        check("rst.rdata", rdata, 32'd0);
        chk1("rst.fault_misalign", fault_misalign, 1'b0);
        chk1("rst.fault_illegal", fault_illegal, 1'b0);
        chk1("rst.fault_bus", fault_bus, 1'b0);
        chk1("rst.mem_req", mem_req, 1'b0);
        chk1("rst.mem_we", mem_we, 1'b0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        chk1("rst.stall", stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        //            ld    st    f3      addr          wdata         gd   r1            r2            lat bt chkrd rdata         fm    fi    fb    maddr         strb     chkwd mwdata
        tbl[0]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        0,   32'hDEADBEEF, 32'h0,        3, 1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        0,   32'h80FFFF00, 32'h0,        3, 1, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[2]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        0,   32'h80FFFF00, 32'h0,        3, 1, 1'b1, 32'h00000080, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 3,   32'h0,        32'h0,        5, 1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0200, 4'b1100, 1'b1, 32'hABCDABCD);
`ifdef MISALIGNED_SPLIT_EN
        tbl[4]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        0,   32'h44332211, 32'h88776655, 5, 2, 1'b1, 32'h55443322, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h1234ABCD, 0,   32'h0,        32'h0,        3, 2, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0200, 4'b1000, 1'b1, 32'hCDABCDAB);
`else
        tbl[4]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        0,   32'h44332211, 32'h88776655, 1, 0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h1234ABCD, 0,   32'h0,        32'h0,        1, 0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
`endif
        tbl[5]  = mk(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        0,   32'h0,        32'h0,        1, 0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
        tbl[6]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        0,   32'h80011234, 32'h0,        3, 1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[7]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        0,   32'h80011234, 32'h0,        3, 1, 1'b1, 32'h00008001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h000000A5, 0,   32'h0,        32'h0,        2, 1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0300, 4'b0010, 1'b1, 32'hA5A5A5A5);
        tbl[9]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hCAFEF00D, 1,   32'h0,        32'h0,        3, 1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0400, 4'b1111, 1'b1, 32'hCAFEF00D);
        tbl[10] = mk(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        0,   32'h0,        32'h0,        1, 0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
        tbl[11] = mk(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        0,   32'h0,        32'h0,        1, 0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0);
        tbl[13] = mk(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        2,   32'h12347FFF, 32'h0,        5, 1, 1'b1, 32'h00007FFF, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[14] = mk(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        0,   32'h0000007F, 32'h0,        3, 1, 1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0);
        tbl[15] = mk(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,        1000, 32'h0,       32'h0,        9, 1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0500, 4'b0000, 1'b0, 32'h0);

        for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

        // Stray rvalid after the timeout must not complete anything.
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk1("stray.done", done, 1'b0);
        check("stray.rdata", rdata, 32'd0);
        @(negedge clk);

        // Reset during REQ1: mem_req drops without waiting for a clock edge.
        load = 1'b1; funct3 = 3'b010; addr = 32'h0000_0600;
        @(negedge clk); #1;
        chk1("rstreq.req_before", mem_req, 1'b1);
        rst = 1'b1; #1;
        chk1("rstreq.req_async", mem_req, 1'b0);
        chk1("rstreq.done", done, 1'b0);
        load = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Give rdata a known nonzero value, then reset during WAIT1.
        run_vec(16, tbl[0]);
        load = 1'b1; funct3 = 3'b010; addr = 32'h0000_0700;
        @(negedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk); #1;
        mem_gnt = 1'b0;
        chk1("rstwait.in_wait", mem_req, 1'b0);
        rst = 1'b1; #1;
        chk1("rstwait.req", mem_req, 1'b0);
        chk1("rstwait.done", done, 1'b0);
        check("rstwait.rdata", rdata, 32'd0);
        load = 1'b0;
        @(negedge clk); rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        saw_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mem_rvalid = 1'b0; #1;
            if (done === 1'b1) saw_done = 1;
        end
        chk1("rstwait.late_rvalid", saw_done, 1'b0);
        check("rstwait.rdata_after", rdata, 32'd0);
        @(negedge clk);
        // FSM back in IDLE: a normal load completes with zero-wait latency.
        run_vec(17, tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Load/store unit between the single-cycle core's MEM stage and the data memory port.
- Consumes the core's load/store decode, effective address and rs2 data.
- Runs a req/gnt/rvalid handshake to data memory, stalling the core until the access completes.
- Returns byte/half/word load data extended to 32 bits for register writeback.

Parameters:
TIMEOUT, 255, max cycles waiting in any wait state for mem_gnt or mem_rvalid before bus error; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
load  in  1  current instruction is a load
store  in  1  current instruction is a store
funct3  in  3  access size/sign (RV32I encoding)
addr  in  32  effective address (rs1+imm)
wdata  in  32  store data (rs2)
stall  out  1  hold PC and instruction; combinational
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result, valid when done=1
fault_misalign  out  1  misaligned access fault, valid with done
fault_illegal  out  1  unsupported funct3, valid with done
fault_bus  out  1  timeout bus error, valid with done
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  32  word address, bits[1:0]=0
mem_wstrb  out  4  byte write strobes
mem_wdata  out  32  lane-aligned write data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Interface: one clock clk; rst is asynchronous and active-high. On rst, state=IDLE; all outputs except stall are 0, including rdata; counters cleared.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
- stall = (load|store) & ~done.
- IDLE with load|store:
  - Latch addr, funct3, wdata and direction.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Any other value -> DONE with fault_illegal.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Misaligned -> DONE with fault_misalign, no memory traffic.
  - Otherwise -> REQ1.
  - Both load and store asserted: treated as illegal.
- REQ1/REQ2:
  - mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata held stable until mem_gnt.
  - On gnt: stores -> DONE (or REQ2 for a split); loads -> WAIT1/WAIT2.
- WAIT1/WAIT2: on mem_rvalid, capture mem_rdata; -> DONE (or REQ2 for a split). mem_rvalid in any other state is ignored.
- Strobes and write data:
  - SB: 0001<<addr[1:0]; SH: 0011<<addr[1:0]; SW: 1111.
  - mem_wdata replicates the byte/half across lanes.
  - Loads drive mem_wstrb=0.
- Load extraction: shift the captured word right by 8*addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- DONE:
  - done=1 for one cycle; rdata/faults valid. Store rdata=0.
  - Next state is IDLE. The core advances on this cycle, so a new access is accepted the cycle after DONE.
  - rdata holds its value until the next DONE.
- Timeout:
  - Counter clears on entering any REQ/WAIT state and increments each cycle there.
  - Reaching TIMEOUT -> DONE with fault_bus, rdata=0; a later stray rvalid is ignored.
- Zero-wait latency (gnt same cycle as req, rvalid next cycle):
  - Load: accept c0, REQ1 c1, WAIT1 c2, DONE c3.
  - Store: accept c0, REQ1 c1, DONE c2.
- Reset mid-operation: mem_req drops asynchronously; state returns to IDLE; no done pulse; in-flight responses are ignored.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined:
  - Misaligned accesses are serviced; fault_misalign is never raised.
  - Accesses within one word (half at offset 1 or 2) use a single beat.
  - Word-crossing accesses (half at offset 3, word at offset 1-3) use two beats:
    - REQ1: addr&~3 with upper-lane strobes.
    - REQ2: (addr&~3)+4 with remaining lower-lane strobes; 0xFFFFFFFC+4 wraps to 0x00000000.
  - Load bytes from both words are merged before extension.
- Undefined: misalignment faults as described in Behaviour; REQ2/WAIT2 are unreachable.

Test Plan:
- LW addr=0x100, zero-wait memory returns 0xDEADBEEF -> mem_addr=0x100, done at c3, rdata=0xDEADBEEF, stall high c0-c2.
- LB addr=0x103, word 0x80FF_FF00 -> rdata=0xFFFFFF80; LBU same access -> rdata=0x00000080.
- SH addr=0x202 wdata=0x1234ABCD, gnt delayed 3 cycles -> mem_req and all mem outputs stable 4 cycles, mem_wstrb=1100, mem_wdata=0xABCDABCD, done 1 cycle after gnt.
- LW addr=0x101:
  - Without MISALIGNED_SPLIT_EN: done at c1 with fault_misalign=1, mem_req never asserted.
  - With it: words 0x44332211@0x100 and 0x88776655@0x104 -> rdata=0x55443322.
- mem_gnt never asserted, TIMEOUT=8 -> done with fault_bus=1 after 8 REQ1 cycles; funct3=011 load -> fault_illegal at c1.
- rst asserted during WAIT1 -> mem_req=0 and state IDLE immediately; rvalid arriving after reset produces no done.
